// File: rtl/braid_sched_pkg.sv
// Shared types for the braid mix scheduler: FSM state, lane index and sizing helpers.
package braid_sched_pkg;

   typedef enum logic [1:0] {IDLE, INJECT, SETTLE, SAMPLE} state_t;

   localparam int unsigned N_LANES_DEFAULT = 3;

   typedef logic [1:0] lane_idx_t;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/braid_rr_arbiter.sv
// Round-robin lane picker: first requesting lane strictly after last_lane, with wrap.
module braid_rr_arbiter
   import braid_sched_pkg::*;
#(
   parameter int unsigned N_LANES = N_LANES_DEFAULT
) (
   input  logic [N_LANES-1:0] req,
   input  lane_idx_t          last_lane,
   output logic [N_LANES-1:0] grant,
   output lane_idx_t          index
);

   logic      found;
   lane_idx_t cand;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned off = 1; off <= N_LANES; off++) begin
         cand = lane_idx_t'((int'(last_lane) + off) % N_LANES);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/braid_mix_scheduler.sv
// Injection/settle/sample sequencer for the braid mixer.
// Optional 16-bit completed-sample counter enabled by BRAID_SCHED_STATS_EN.
module braid_mix_scheduler
   import braid_sched_pkg::*;
#(
   parameter int unsigned N_LANES       = N_LANES_DEFAULT,
   parameter int unsigned PULSE_CYCLES  = 4,
   parameter int unsigned SETTLE_CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_LANES-1:0] req_i,
   input  logic               abort_i,
   input  logic               sample_ready_i,
   output logic [N_LANES-1:0] gnt_o,
   output logic [N_LANES-1:0] valve_o,
   output logic               busy_o,
   output logic               sample_valid_o,
   output logic [1:0]         sample_lane_o
`ifdef BRAID_SCHED_STATS_EN
   ,
   output logic [15:0]        inj_count_o
`endif
);

   localparam int unsigned CntW = $clog2(max2(PULSE_CYCLES, SETTLE_CYCLES) + 1);

   state_t             state_q;
   lane_idx_t          last_lane_q;
   logic [CntW-1:0]    cnt_q;
   logic [N_LANES-1:0] arb_grant;
   lane_idx_t          arb_index;

   braid_rr_arbiter #(
      .N_LANES (N_LANES)
   ) u_arb (
      .req       (req_i),
      .last_lane (last_lane_q),
      .grant     (arb_grant),
      .index     (arb_index)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         last_lane_q    <= lane_idx_t'(N_LANES - 1);
         cnt_q          <= '0;
         gnt_o          <= '0;
         valve_o        <= '0;
         busy_o         <= 1'b0;
         sample_valid_o <= 1'b0;
         sample_lane_o  <= '0;
      end else if (abort_i) begin
         // last_lane_q keeps the aborted lane so rotation continues past it
         state_q        <= IDLE;
         cnt_q          <= '0;
         gnt_o          <= '0;
         valve_o        <= '0;
         busy_o         <= 1'b0;
         sample_valid_o <= 1'b0;
         sample_lane_o  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req_i) begin
                  state_q     <= INJECT;
                  last_lane_q <= arb_index;
                  gnt_o       <= arb_grant;
                  valve_o     <= arb_grant;
                  busy_o      <= 1'b1;
                  cnt_q       <= CntW'(PULSE_CYCLES - 1);
               end
            end
            INJECT: begin
               gnt_o <= '0;
               if (cnt_q == '0) begin
                  state_q <= SETTLE;
                  valve_o <= '0;
                  cnt_q   <= CntW'(SETTLE_CYCLES - 1);
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  state_q        <= SAMPLE;
                  sample_valid_o <= 1'b1;
                  sample_lane_o  <= last_lane_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SAMPLE: begin
               if (sample_ready_i) begin
                  state_q        <= IDLE;
                  busy_o         <= 1'b0;
                  sample_valid_o <= 1'b0;
                  sample_lane_o  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef BRAID_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inj_count_o <= '0;
      end else if (!abort_i && state_q == SAMPLE && sample_valid_o && sample_ready_i &&
                   inj_count_o != 16'hFFFF) begin
         inj_count_o <= inj_count_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_braid_mix_scheduler.sv
// Directed self-checking bench for braid_mix_scheduler (default parameters).
module tb_braid_mix_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req_i;
   logic       abort_i;
   logic       sample_ready_i;
   logic [2:0] gnt_o;
   logic [2:0] valve_o;
   logic       busy_o;
   logic       sample_valid_o;
   logic [1:0] sample_lane_o;
`ifdef BRAID_SCHED_STATS_EN
   logic [15:0] inj_count_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   braid_mix_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_i          (req_i),
      .abort_i        (abort_i),
      .sample_ready_i (sample_ready_i),
      .gnt_o          (gnt_o),
      .valve_o        (valve_o),
      .busy_o         (busy_o),
      .sample_valid_o (sample_valid_o),
      .sample_lane_o  (sample_lane_o)
`ifdef BRAID_SCHED_STATS_EN
      ,
      .inj_count_o    (inj_count_o)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_i = '0; abort_i = 1'b0; sample_ready_i = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req_i = 3'b111; abort_i = 1'b0; sample_ready_i = 1'b1;
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (gnt_o !== 3'b000) begin errors++;
         $display("FAIL reset_gnt got=%b want=000", gnt_o); end
      checks++; if (valve_o !== 3'b000) begin errors++;
         $display("FAIL reset_valve got=%b want=000", valve_o); end
      checks++; if (busy_o !== 1'b0) begin errors++;
         $display("FAIL reset_busy got=%b want=0", busy_o); end
      checks++; if (sample_valid_o !== 1'b0 || sample_lane_o !== 2'd0) begin errors++;
         $display("FAIL reset_sample got=%b/%0d want=0/0", sample_valid_o, sample_lane_o); end
      rst_n = 1'b1; req_i = '0; sample_ready_i = 1'b0;
   endtask

   task automatic test_single();
      int n = 0;
      int vcnt = 0;
      logic vbad = 1'b0;
      logic [2:0] g1 = '0;
      do_reset();
      req_i = 3'b001;
      while (!sample_valid_o && n < 100) begin
         tick(); n++;
         if (n == 1) begin g1 = gnt_o; req_i = '0; end
         if (n == 2 && gnt_o !== 3'b000) vbad = 1'b1;
         if (valve_o !== 3'b000) begin vcnt++; if (valve_o !== 3'b001) vbad = 1'b1; end
      end
      checks++; if (g1 !== 3'b001) begin errors++;
         $display("FAIL single_gnt got=%b want=001", g1); end
      checks++; if (vbad) begin errors++;
         $display("FAIL single_valve_shape got=bad want=one-hot lane0, gnt one cycle"); end
      checks++; if (vcnt != 4) begin errors++;
         $display("FAIL single_valve_cycles got=%0d want=4", vcnt); end
      checks++; if (n != 37) begin errors++;
         $display("FAIL single_valid_latency got=%0d want=37", n); end
      checks++; if (sample_lane_o !== 2'd0 || busy_o !== 1'b1) begin errors++;
         $display("FAIL single_lane got=%0d busy=%b want=0 busy=1", sample_lane_o, busy_o); end
      sample_ready_i = 1'b1;
      tick();
      sample_ready_i = 1'b0;
      checks++; if (sample_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
         $display("FAIL single_handshake got=valid%b busy%b want=0/0", sample_valid_o, busy_o);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] g[4];
      int gc[4];
      int ng = 0;
      logic multi = 1'b0;
      do_reset();
      req_i = 3'b111; sample_ready_i = 1'b1;
      for (int c = 1; c <= 160; c++) begin
         tick();
         if ($countones(valve_o) > 1) multi = 1'b1;
         if (gnt_o !== 3'b000 && ng < 4) begin g[ng] = gnt_o; gc[ng] = c; ng++; end
      end
      req_i = '0; sample_ready_i = 1'b0;
      checks++; if (ng != 4) begin errors++;
         $display("FAIL rr_count got=%0d want=4", ng); end
      else begin
         checks++; if (g[0] !== 3'b001 || g[1] !== 3'b010 || g[2] !== 3'b100 || g[3] !== 3'b001)
         begin errors++;
            $display("FAIL rr_order got=%b,%b,%b,%b want=001,010,100,001", g[0], g[1], g[2], g[3]);
         end
         checks++; if (gc[1] - gc[0] != 38 || gc[3] - gc[2] != 38) begin errors++;
            $display("FAIL rr_spacing got=%0d,%0d want=38,38", gc[1] - gc[0], gc[3] - gc[2]);
         end
      end
      checks++; if (multi) begin errors++;
         $display("FAIL rr_valve_onehot got=multiple want=at most one"); end
   endtask

   task automatic test_abort();
      logic saw_valid = 1'b0;
      do_reset();
      req_i = 3'b010;
      tick();
      checks++; if (gnt_o !== 3'b010 || valve_o !== 3'b010) begin errors++;
         $display("FAIL abort_grant got=%b/%b want=010/010", gnt_o, valve_o); end
      abort_i = 1'b1; req_i = 3'b111;
      tick();
      checks++; if (valve_o !== 3'b000 || busy_o !== 1'b0) begin errors++;
         $display("FAIL abort_close got=valve%b busy%b want=000/0", valve_o, busy_o); end
      tick();
      checks++; if (gnt_o !== 3'b000 || busy_o !== 1'b0) begin errors++;
         $display("FAIL abort_prio_grant got=gnt%b busy%b want=000/0", gnt_o, busy_o); end
      abort_i = 1'b0; req_i = '0;
      repeat (45) begin tick(); if (sample_valid_o) saw_valid = 1'b1; end
      checks++; if (saw_valid) begin errors++;
         $display("FAIL abort_no_valid got=1 want=0"); end
      req_i = 3'b111;
      tick();
      req_i = '0;
      checks++; if (gnt_o !== 3'b100 || valve_o !== 3'b100) begin errors++;
         $display("FAIL abort_next_lane got=%b/%b want=100/100", gnt_o, valve_o); end
   endtask

   task automatic test_backpressure();
      int n = 0;
      logic stable = 1'b1;
      do_reset();
      req_i = 3'b100;
      while (!sample_valid_o && n < 100) begin tick(); n++; req_i = '0; end
      checks++; if (n != 37) begin errors++;
         $display("FAIL bp_latency got=%0d want=37", n); end
      repeat (10) begin
         tick();
         if (sample_valid_o !== 1'b1 || sample_lane_o !== 2'd2) stable = 1'b0;
      end
      checks++; if (!stable) begin errors++;
         $display("FAIL bp_hold got=unstable want=valid=1 lane=2 for 10 cycles"); end
      sample_ready_i = 1'b1;
      tick();
      sample_ready_i = 1'b0;
      checks++; if (sample_valid_o !== 1'b0 || busy_o !== 1'b0 || sample_lane_o !== 2'd0)
      begin errors++;
         $display("FAIL bp_release got=valid%b busy%b lane%0d want=0/0/0",
                  sample_valid_o, busy_o, sample_lane_o);
      end
   endtask

   task automatic test_reset_settle();
      do_reset();
      req_i = 3'b010;
      tick();
      req_i = '0;
      repeat (9) tick();
      checks++; if (busy_o !== 1'b1 || valve_o !== 3'b000) begin errors++;
         $display("FAIL rs_in_settle got=busy%b valve%b want=1/000", busy_o, valve_o); end
      rst_n = 1'b0;
      tick();
      checks++; if ({gnt_o, valve_o, busy_o, sample_valid_o, sample_lane_o} !== 10'd0) begin
         errors++;
         $display("FAIL rs_outputs got=%b want=0", {gnt_o, valve_o, busy_o, sample_valid_o,
                  sample_lane_o});
      end
      rst_n = 1'b1; req_i = 3'b111;
      tick();
      req_i = '0;
      checks++; if (gnt_o !== 3'b001) begin errors++;
         $display("FAIL rs_first_grant got=%b want=001", gnt_o); end
   endtask

`ifdef BRAID_SCHED_STATS_EN
   task automatic test_stats();
      int n = 0;
      do_reset();
      checks++; if (inj_count_o !== 16'd0) begin errors++;
         $display("FAIL stats_reset got=%0d want=0", inj_count_o); end
      req_i = 3'b001; sample_ready_i = 1'b1;
      while (busy_o !== 1'b0 || n == 0) begin
         tick(); n++; req_i = '0;
         if (n > 100) break;
      end
      sample_ready_i = 1'b0;
      checks++; if (inj_count_o !== 16'd1) begin errors++;
         $display("FAIL stats_one got=%0d want=1", inj_count_o); end
      req_i = 3'b001;
      repeat (40) begin tick(); req_i = '0; end
      abort_i = 1'b1; sample_ready_i = 1'b1;
      tick();
      abort_i = 1'b0; sample_ready_i = 1'b0;
      checks++; if (inj_count_o !== 16'd1) begin errors++;
         $display("FAIL stats_abort got=%0d want=1", inj_count_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_backpressure();
      test_reset_settle();
`ifdef BRAID_SCHED_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
